sr_button_ctrl: RTL

- Upstream command stage for the team's sr_ff.
- Takes two raw, asynchronous, bouncy push-button inputs (set, clear) and synchronises and debounces each one.
- Converts each debounced press into a single-cycle s or r pulse.
- Guarantees the downstream flip-flop never sees s=1 and r=1 together.

---
 rtl/sr_button_ctrl.sv | 138 +++++++++++++
 1 files changed

// File: rtl/sr_button_ctrl.sv
// Purpose: sync + debounce two raw push-buttons; emit one-cycle s/r pulses to sr_ff, never both at once.
// Latency: raw edge held from before edge k -> s/r pulse high from edge k+3+DEBOUNCE_CYCLES.
// Backpressure: none; sr_ff is always ready and pulses are fire-and-forget.
// Optional: define SR_CTRL_CONFLICT_EN to turn a simultaneous press into a conflict pulse.
module sr_button_ctrl #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int CNT_W           = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_set_raw,
  input  logic btn_clr_raw,
  output logic s,
  output logic r,
  output logic conflict
);

  // Counter value on which the D-th consecutive differing sample is seen.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  // Channel 0 is set, channel 1 is clear; both channels are identical.
  logic [1:0] raw_in;
  logic [1:0] press;

  assign raw_in = {btn_clr_raw, btn_set_raw};

  for (genvar g = 0; g < 2; g++) begin : g_chan
    logic             sync1;
    logic             sync2;
    logic             stable;
    logic             stable_d;
    logic             press_q;
    logic [CNT_W-1:0] cnt;

    // Two-flop synchroniser for the asynchronous button input.
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        sync1 <= 1'b0;
        sync2 <= 1'b0;
      end else begin
        sync1 <= raw_in[g];
        sync2 <= sync1;
      end
    end

    // Accept a new level only after it has differed from stable for
    // DEBOUNCE_CYCLES consecutive cycles; any bounce back restarts the count.
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        stable <= 1'b0;
        cnt    <= '0;
      end else if (sync2 != stable) begin
        if (cnt == CNT_LAST) begin
          stable <= sync2;
          cnt    <= '0;
        end else begin
          cnt <= cnt + CNT_ONE;
        end
      end else begin
        cnt <= '0;
      end
    end

    // Registered rising-edge detect on the debounced level; releases are ignored.
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        stable_d <= 1'b0;
        press_q  <= 1'b0;
      end else begin
        stable_d <= stable;
        press_q  <= stable & ~stable_d;
      end
    end

    assign press[g] = press_q;
  end

`ifdef SR_CTRL_CONFLICT_EN
  logic s_nxt;
  logic r_nxt;
  logic conflict_nxt;

  // A simultaneous press issues neither command and flags a conflict instead.
  always_comb begin
    s_nxt        = 1'b0;
    r_nxt        = 1'b0;
    conflict_nxt = 1'b0;
    if (press[0] && press[1]) begin
      conflict_nxt = 1'b1;
    end else begin
      s_nxt = press[0];
      r_nxt = press[1];
    end
  end

  // Output register: one-cycle command pulses and conflict flag.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s        <= 1'b0;
      r        <= 1'b0;
      conflict <= 1'b0;
    end else begin
      s        <= s_nxt;
      r        <= r_nxt;
      conflict <= conflict_nxt;
    end
  end
`else
  logic s_nxt;
  logic r_nxt;

  // A simultaneous press resolves to clear: r wins, s is suppressed.
  always_comb begin
    s_nxt = 1'b0;
    r_nxt = 1'b0;
    if (press[1]) begin
      r_nxt = 1'b1;
    end else if (press[0]) begin
      s_nxt = 1'b1;
    end
  end

  // Output register: one-cycle command pulses.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s <= 1'b0;
      r <= 1'b0;
    end else begin
      s <= s_nxt;
      r <= r_nxt;
    end
  end

  assign conflict = 1'b0;
`endif

endmodule
